// File: rtl/any1_pkg.sv
// Shared types and constants for the bitfield packer datapath.
package any1_pkg;

  localparam int PACK_FILL_W = 7;
  localparam int PACK_ACC_W  = 128;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } PackOutState;

endpackage

// File: rtl/any1_bfmask.sv
// Low-order mask generator: sets bits [wid_m1:0] of a 64-bit word.
module any1_bfmask (
  input  logic [5:0]  wid_m1,
  output logic [63:0] mask
);

  // Right-shift an all-ones word so exactly wid_m1+1 ones remain.
  always_comb begin
    mask = 64'hFFFF_FFFF_FFFF_FFFF >> (7'd63 - {1'b0, wid_m1});
  end

endmodule

// File: rtl/any1_bitfield_packer.sv
// Packs a stream of 1..64-bit fields LSB-first into 64-bit words;
// a flush emits the residual partial word tagged with its bit count.
module any1_bitfield_packer
  import any1_pkg::*;
#(
  parameter int DWIDTH = 64
) (
  input  logic                   rst_i,
  input  logic                   clk_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DWIDTH-1:0]      in_val_i,
  input  logic [5:0]             in_wid_i,
  input  logic                   flush_i,
  output logic                   flush_done_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DWIDTH-1:0]      out_data_o,
  output logic [PACK_FILL_W-1:0] out_bits_o,
  output logic                   out_last_o
);

  PackOutState                state_r;
  PackOutState                state_nxt_s;
  logic [PACK_ACC_W-1:0]      acc_r;
  logic [PACK_ACC_W-1:0]      acc_nxt_s;
  logic [PACK_ACC_W-1:0]      acc_sum_s;
  logic [PACK_FILL_W-1:0]     fill_r;
  logic [PACK_FILL_W-1:0]     fill_nxt_s;
  logic [PACK_FILL_W-1:0]     nf_s;
  logic [PACK_FILL_W-1:0]     w_s;
  logic [63:0]                fmask_s;
  logic [63:0]                zmask_s;
  logic [5:0]                 fill_m1_s;
  logic                       in_ready_s;
  logic                       fld_acc_s;
  logic                       flush_acc_s;
  logic                       load_s;
  logic [63:0]                ld_data_s;
  logic [PACK_FILL_W-1:0]     ld_bits_s;
  logic                       ld_last_s;
  logic [DWIDTH-1:0]          out_data_r;
  logic [PACK_FILL_W-1:0]     out_bits_r;
  logic                       out_last_r;
  logic                       flush_done_r;

  // fill_m1 wraps when fill is 0; the flush path never uses the mask then.
  assign fill_m1_s = fill_r[5:0] - 6'd1;

  any1_bfmask u_field_mask (
    .wid_m1 (in_wid_i),
    .mask   (fmask_s)
  );

  any1_bfmask u_flush_mask (
    .wid_m1 (fill_m1_s),
    .mask   (zmask_s)
  );

  // Handshake, accept qualification and accumulator next-state.
  always_comb begin
    in_ready_s  = (state_r == EMPTY) | out_ready_i;
    fld_acc_s   = in_valid_i & in_ready_s;
    flush_acc_s = flush_i & ~in_valid_i & in_ready_s;
    w_s         = {1'b0, in_wid_i} + 7'd1;
    nf_s        = fill_r + w_s;
    acc_sum_s   = acc_r | ({64'd0, in_val_i & fmask_s} << fill_r);
    acc_nxt_s   = acc_r;
    fill_nxt_s  = fill_r;
    load_s      = 1'b0;
    ld_data_s   = 64'd0;
    ld_bits_s   = 7'd0;
    ld_last_s   = 1'b0;
    if (fld_acc_s) begin
      if (nf_s >= 7'd64) begin
        load_s     = 1'b1;
        ld_data_s  = acc_sum_s[63:0];
        ld_bits_s  = 7'd64;
        acc_nxt_s  = {64'd0, acc_sum_s[127:64]};
        fill_nxt_s = nf_s - 7'd64;
      end else begin
        acc_nxt_s  = acc_sum_s;
        fill_nxt_s = nf_s;
      end
    end else if (flush_acc_s) begin
      if (fill_r != 7'd0) begin
        load_s    = 1'b1;
        ld_data_s = acc_r[63:0] & zmask_s;
        ld_bits_s = fill_r;
        ld_last_s = 1'b1;
      end else begin
        load_s    = 1'b0;
      end
      acc_nxt_s  = {PACK_ACC_W{1'b0}};
      fill_nxt_s = 7'd0;
    end else begin
      load_s = 1'b0;
    end
  end

  // Output-register FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (load_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      HOLD: begin
        if (load_s) begin
          state_nxt_s = HOLD;
        end else if (out_ready_i) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= EMPTY;
      acc_r        <= {PACK_ACC_W{1'b0}};
      fill_r       <= 7'd0;
      out_data_r   <= {DWIDTH{1'b0}};
      out_bits_r   <= 7'd0;
      out_last_r   <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      acc_r        <= acc_nxt_s;
      fill_r       <= fill_nxt_s;
      flush_done_r <= flush_acc_s;
      if (load_s) begin
        out_data_r <= ld_data_s;
        out_bits_r <= ld_bits_s;
        out_last_r <= ld_last_s;
      end else begin
        out_data_r <= out_data_r;
        out_bits_r <= out_bits_r;
        out_last_r <= out_last_r;
      end
    end
  end

  // Port outputs; in_ready is the lone combinational path from out_ready.
  always_comb begin
    out_valid_o  = (state_r == HOLD);
    in_ready_o   = ~out_valid_o | out_ready_i;
    out_data_o   = out_data_r;
    out_bits_o   = out_bits_r;
    out_last_o   = out_last_r;
    flush_done_o = flush_done_r;
  end

endmodule

// File: tb/tb_any1_bitfield_packer.sv
// Randomized bench for any1_bitfield_packer against a bit-queue reference model.
module tb_any1_bitfield_packer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] in_val_i;
  logic [5:0]  in_wid_i;
  logic        flush_i;
  logic        flush_done_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_data_o;
  logic [6:0]  out_bits_o;
  logic        out_last_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: pending bits in arrival order plus expected output register.
  bit          q[$];
  logic        exp_valid;
  logic [63:0] exp_data;
  logic [6:0]  exp_bits;
  logic        exp_last;
  logic        exp_fd;

  always #5 clk = ~clk;

  any1_bitfield_packer #(.DWIDTH(64)) dut (
    .rst_i        (rst_i),
    .clk_i        (clk),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_val_i     (in_val_i),
    .in_wid_i     (in_wid_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_bits_o   (out_bits_o),
    .out_last_o   (out_last_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, check DUT against the model, then advance both.
  task automatic drive(input logic v, input logic [5:0] wid, input logic [63:0] val,
                       input logic fl, input logic ordy);
    logic        rdy;
    logic        got_word;
    logic [63:0] wd;
    logic [6:0]  nb;
    logic        lst;
    in_valid_i  = v;
    in_wid_i    = wid;
    in_val_i    = val;
    flush_i     = fl;
    out_ready_i = ordy;
    @(negedge clk);
    chk("out_valid", out_valid_o, exp_valid);
    chk("in_ready", in_ready_o, !exp_valid || ordy);
    chk("flush_done", flush_done_o, exp_fd);
    if (exp_valid) begin
      chk("out_data", out_data_o, exp_data);
      chk("out_bits", out_bits_o, exp_bits);
      chk("out_last", out_last_o, exp_last);
    end
    rdy      = !exp_valid || ordy;
    got_word = 1'b0;
    wd       = 64'd0;
    nb       = 7'd0;
    lst      = 1'b0;
    if (v && rdy) begin
      for (int i = 0; i < int'(wid) + 1; i++) q.push_back(val[i]);
      if (q.size() >= 64) begin
        for (int i = 0; i < 64; i++) wd[i] = q.pop_front();
        got_word = 1'b1;
        nb       = 7'd64;
      end
    end else if (fl && rdy) begin
      if (q.size() > 0) begin
        nb = 7'(q.size());
        for (int i = 0; i < int'(nb); i++) wd[i] = q.pop_front();
        got_word = 1'b1;
        lst      = 1'b1;
      end
    end
    exp_fd = fl && !v && rdy;
    if (got_word) begin
      exp_valid = 1'b1;
      exp_data  = wd;
      exp_bits  = nb;
      exp_last  = lst;
    end else if (ordy) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    in_val_i    = 64'd0;
    in_wid_i    = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    q.delete();
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_data", out_data_o, 64'd0);
    chk("rst_out_bits", out_bits_o, 7'd0);
    chk("rst_out_last", out_last_o, 1'b0);
    chk("rst_flush_done", flush_done_o, 1'b0);
    chk("rst_in_ready", in_ready_o, 1'b1);
  endtask

  initial begin
    do_reset();

    // Eight full-width fields, each emitted immediately.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'd63, 64'(i), 1'b0, 1'b1);
      chk("full_word", out_data_o, 64'(i));
      chk("full_bits", out_bits_o, 7'd64);
    end
    drive(1'b0, 6'd0, 64'd0, 1'b0, 1'b1);

    // Byte packing.
    for (int i = 1; i <= 8; i++) drive(1'b1, 6'd7, 64'(i), 1'b0, 1'b1);
    chk("byte_word", out_data_o, 64'h0807060504030201);
    chk("byte_valid", out_valid_o, 1'b1);

    // Straddle and flush.
    drive(1'b1, 6'd39, 64'hFF_FFFF_FFFF, 1'b0, 1'b1);
    drive(1'b1, 6'd39, 64'hFF_FFFF_FFFF, 1'b0, 1'b1);
    chk("straddle_word", out_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, 6'd39, 64'hFF_FFFF_FFFF, 1'b0, 1'b1);
    chk("straddle_none", out_valid_o, 1'b0);
    drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b1);
    chk("flush_word", out_data_o, 64'h00FF_FFFF_FFFF_FFFF);
    chk("flush_bits", out_bits_o, 7'd56);
    chk("flush_last", out_last_o, 1'b1);

    // Masking, then an empty flush.
    drive(1'b1, 6'd3, 64'hFFFF_FFFF_FFFF_FFF5, 1'b0, 1'b1);
    drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b1);
    chk("mask_word", out_data_o, 64'h5);
    chk("mask_bits", out_bits_o, 7'd4);
    drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b1);
    chk("empty_flush_valid", out_valid_o, 1'b0);
    chk("empty_flush_done", flush_done_o, 1'b1);
    drive(1'b0, 6'd0, 64'd0, 1'b0, 1'b1);

    // Backpressure with a stalled word, then release with a simultaneous load.
    drive(1'b1, 6'd63, 64'hA5A5_0000_1111_2222, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 6'd63, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
    chk("bp_stable", out_data_o, 64'hA5A5_0000_1111_2222);
    drive(1'b1, 6'd63, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1);
    chk("bp_reload_valid", out_valid_o, 1'b1);
    chk("bp_reload_data", out_data_o, 64'hDEAD_BEEF_0000_0001);

    // Priority of a field over a simultaneous flush.
    drive(1'b1, 6'd9, 64'h3FF, 1'b1, 1'b1);
    chk("prio_no_done", flush_done_o, 1'b0);
    drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b1);
    chk("prio_flush_bits", out_bits_o, 7'd10);

    // Reset with 20 residual bits discards them.
    drive(1'b1, 6'd19, 64'hF_FFFF, 1'b0, 1'b1);
    do_reset();
    drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b1);
    chk("post_rst_flush_valid", out_valid_o, 1'b0);
    chk("post_rst_flush_done", flush_done_o, 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)),
            {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 3) != 0));
    end
    drive(1'b0, 6'd0, 64'd0, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 6'd0, 64'd0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
